// File: rtl/mem_pkg.sv
// Shared constants and helpers for the unified instruction/data memory responder.
// Holds RV32I load/store funct3 encodings, the default fetch-starvation limit,
// and small pure functions for access legality and byte-lane steering.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Consecutive data grants tolerated while a fetch waits.
    localparam int STARVE_MAX_DEFAULT = 4;

    // 1 when the access is misaligned for its width or the funct3 is illegal
    // for the direction (unsigned variants exist only for loads).
    function automatic logic mem_access_err(input logic we, input logic [2:0] f3,
                                            input logic [1:0] alo);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = alo[0];
            F3_W:    err = |alo;
            F3_BU:   err = we;
            F3_HU:   err = we | alo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Which of the four byte lanes a legal store touches.
    function automatic logic [3:0] store_lane_mask(input logic [2:0] f3, input logic [1:0] alo);
        logic [3:0] mask;
        case (f3)
            F3_B:    mask = 4'b0001 << alo;
            F3_H:    mask = alo[1] ? 4'b1100 : 4'b0011;
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Replicate the store operand so every lane sees its correct byte;
    // the lane mask then picks which lanes actually capture it.
    function automatic logic [31:0] store_lane_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lane_bank.sv
// One byte-wide storage lane: synchronous write, registered read of the indexed byte.
// Latency: read data valid the cycle after the index is presented.
// No flow control; the parent decides when a read or write is meaningful.
module mem_lane_bank #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [7:0]       i_wdat,
    output logic [7:0]       o_rdat
);

    logic [7:0] r_mem [0:(2**IDX_W)-1];
    logic [7:0] r_rdat;

    // Write the addressed byte and capture the addressed byte (old value on a write cycle).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdat;
        end
        r_rdat <= r_mem[i_idx];
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/unified_mem_responder.sv
// Unified fetch/load-store memory: one access per cycle, data-priority arbitration
// with a fetch starvation limit. Latency: response valid the cycle after acceptance.
// Requests are held by the requester until ready; responses have no backpressure.
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_err,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_funct3,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_if_vld;
    logic             r_d_vld;
    logic             r_err;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [1:0]       r_alo;

    logic             w_force_if;
    logic             w_d_err;
    logic             w_if_err;
    logic             w_store;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_lane_we;
    logic [31:0]      w_lane_wdat;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    // Arbitration: data wins unless the fetch has already lost STARVE_MAX times in a row.
    assign w_force_if   = if_req_valid & d_req_valid & (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign d_req_ready  = ~reset & d_req_valid & ~w_force_if;
    assign if_req_ready = ~reset & if_req_valid & (~d_req_valid | w_force_if);

    assign w_if_err    = |if_req_addr[1:0];
    assign w_d_err     = mem_access_err(d_req_we, d_req_funct3, d_req_addr[1:0]);
    assign w_store     = d_req_ready & d_req_we & ~w_d_err;
    assign w_idx       = if_req_ready ? if_req_addr[ADDR_W-1:2] : d_req_addr[ADDR_W-1:2];
    assign w_lane_we   = w_store ? store_lane_mask(d_req_funct3, d_req_addr[1:0]) : 4'b0000;
    assign w_lane_wdat = store_lane_data(d_req_funct3, d_req_wdata);

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            mem_lane_bank #(.IDX_W(IDX_W)) u_lane (
                .clk    (clk),
                .i_we   (w_lane_we[k]),
                .i_idx  (w_idx),
                .i_wdat (w_lane_wdat[8*k +: 8]),
                .o_rdat (w_word[8*k +: 8])
            );
        end
    endgenerate

    // Count data grants that bypassed a waiting fetch; anything else restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (d_req_ready & if_req_valid) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Capture what the accepted access needs to shape its response next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_vld <= 1'b0;
            r_d_vld  <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_f3     <= F3_W;
            r_alo    <= 2'b00;
        end else begin
            r_if_vld <= if_req_ready;
            r_d_vld  <= d_req_ready;
            if (if_req_ready) begin
                r_err <= w_if_err;
                r_we  <= 1'b0;
                r_f3  <= F3_W;
                r_alo <= 2'b00;
            end else if (d_req_ready) begin
                r_err <= w_d_err;
                r_we  <= d_req_we;
                r_f3  <= d_req_funct3;
                r_alo <= d_req_addr[1:0];
            end
        end
    end

    assign w_byte = w_word[8*r_alo +: 8];
    assign w_half = r_alo[1] ? w_word[31:16] : w_word[15:0];

    // Width selection and sign/zero extension of the registered lane bytes.
    always_comb begin
        w_load = 32'h0;
        case (r_f3)
            F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   w_load = {24'h0, w_byte};
            F3_H:    w_load = {{16{w_half[15]}}, w_half};
            F3_HU:   w_load = {16'h0, w_half};
            F3_W:    w_load = w_word;
            default: w_load = 32'h0;
        endcase
    end

    // Data is forced to zero unless a successful read is being reported, so the
    // unreset lane contents never leak out after reset, on stores, or on errors.
    assign if_rsp_valid = r_if_vld;
    assign if_rsp_err   = r_if_vld & r_err;
    assign if_rsp_data  = (r_if_vld & ~r_err) ? w_word : 32'h0;
    assign d_rsp_valid  = r_d_vld;
    assign d_rsp_err    = r_d_vld & r_err;
    assign d_rsp_data   = (r_d_vld & ~r_err & ~r_we) ? w_load : 32'h0;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized and directed checks of unified_mem_responder against a byte-array model.
// Expected grants come from a count of fetch losses; responses one cycle after grant.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_unified_mem_responder;
    import mem_pkg::*;

    localparam int ADDR_W = 9;
    localparam int SMAX   = 4;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              if_rsp_err;
    logic              d_req_valid;
    logic              d_req_we;
    logic [2:0]        d_req_funct3;
    logic [ADDR_W-1:0] d_req_addr;
    logic [31:0]       d_req_wdata;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_data;
    logic              d_rsp_err;

    unified_mem_responder #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_funct3(d_req_funct3),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic [7:0]  mem_m [0:MEM_SZ-1];
    int          fetch_losses = 0;
    logic        exp_if_vld = 1'b0, exp_if_err = 1'b0;
    logic [31:0] exp_if_dat = 32'h0;
    logic        exp_d_vld = 1'b0, exp_d_err = 1'b0;
    logic [31:0] exp_d_dat = 32'h0;
    logic        last_gif = 1'b1, last_gd = 1'b1;
    logic        dut_dgnt;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    // One clock cycle: drive a request pair, check readies and last cycle's responses,
    // then let the model carry out whatever was granted.
    task automatic step(input logic ifv, input logic [ADDR_W-1:0] ifa,
                        input logic dv, input logic we, input logic [2:0] f3,
                        input logic [ADDR_W-1:0] da, input logic [31:0] wd);
        logic        g_if, g_d, e, legal;
        logic [31:0] v;
        int          sz, a;
        if_req_valid = ifv; if_req_addr = ifa;
        d_req_valid = dv; d_req_we = we; d_req_funct3 = f3; d_req_addr = da; d_req_wdata = wd;
        @(negedge clk);
        if (ifv && dv) begin
            g_d  = (fetch_losses < SMAX);
            g_if = !g_d;
        end else begin
            g_d  = dv;
            g_if = ifv;
        end
        dut_dgnt = d_req_ready;
        chk_eq("if_req_ready", {31'h0, if_req_ready}, {31'h0, g_if});
        chk_eq("d_req_ready", {31'h0, d_req_ready}, {31'h0, g_d});
        chk_eq("if_rsp_valid", {31'h0, if_rsp_valid}, {31'h0, exp_if_vld});
        if (exp_if_vld) begin
            chk_eq("if_rsp_data", if_rsp_data, exp_if_dat);
            chk_eq("if_rsp_err", {31'h0, if_rsp_err}, {31'h0, exp_if_err});
        end
        chk_eq("d_rsp_valid", {31'h0, d_rsp_valid}, {31'h0, exp_d_vld});
        if (exp_d_vld) begin
            chk_eq("d_rsp_data", d_rsp_data, exp_d_dat);
            chk_eq("d_rsp_err", {31'h0, d_rsp_err}, {31'h0, exp_d_err});
        end
        fetch_losses = (g_d && ifv) ? fetch_losses + 1 : 0;
        exp_if_vld = g_if;
        if (g_if) begin
            exp_if_err = (ifa[1:0] != 2'b00);
            exp_if_dat = exp_if_err ? 32'h0 : mword(int'(ifa));
        end
        exp_d_vld = g_d;
        if (g_d) begin
            case (f3[1:0])
                2'd0:    sz = 1;
                2'd1:    sz = 2;
                2'd2:    sz = 4;
                default: sz = 0;
            endcase
            legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
            a = int'(da);
            e = !legal || sz == 0 || (a % sz) != 0;
            v = 32'h0;
            if (!e && we) begin
                for (int i = 0; i < sz; i++) mem_m[a+i] = wd[8*i +: 8];
            end else if (!e) begin
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_m[a+i];
                if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
            end
            exp_d_dat = v;
            exp_d_err = e;
        end
        last_gif = g_if;
        last_gd  = g_d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, F3_W, '0, 32'h0);
    endtask

    logic [11:0]       pat;
    logic              c_ifv, c_dv, c_we;
    logic [ADDR_W-1:0] c_ifa, c_da;
    logic [2:0]        c_f3;
    logic [31:0]       c_wd;
    int                fa;

    initial begin
        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_funct3 = F3_W; d_req_addr = '0; d_req_wdata = '0;
        @(negedge clk);
        chk_eq("rst_if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
        chk_eq("rst_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
        chk_eq("rst_d_rsp_data", d_rsp_data, 32'h0);
        chk_eq("rst_if_rsp_data", if_rsp_data, 32'h0);
        chk_eq("rst_errs", {30'h0, if_rsp_err, d_rsp_err}, 32'h0);
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        chk_eq("rst_readies", {30'h0, if_req_ready, d_req_ready}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Preload every word so fetches and loads have known contents.
        for (int w = 0; w < MEM_SZ / 4; w++)
            step(1'b0, '0, 1'b1, 1'b1, F3_W, ADDR_W'(4 * w), $urandom);

        step(1'b0, '0, 1'b1, 1'b1, F3_W, 9'h010, 32'hDEADBEEF);
        chk_eq("sw_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
        step(1'b0, '0, 1'b1, 1'b0, F3_W, 9'h010, 32'h0);
        chk_eq("lw_dat", d_rsp_data, 32'hDEADBEEF);
        chk_eq("lw_err", {31'h0, d_rsp_err}, 32'h0);
        step(1'b0, '0, 1'b1, 1'b1, F3_B, 9'h013, 32'h12345680);
        step(1'b0, '0, 1'b1, 1'b0, F3_B, 9'h013, 32'h0);
        chk_eq("lb_dat", d_rsp_data, 32'hFFFFFF80);
        step(1'b0, '0, 1'b1, 1'b0, F3_BU, 9'h013, 32'h0);
        chk_eq("lbu_dat", d_rsp_data, 32'h00000080);
        step(1'b0, '0, 1'b1, 1'b0, F3_H, 9'h012, 32'h0);
        chk_eq("lh_dat", d_rsp_data, 32'hFFFF80AD);
        step(1'b0, '0, 1'b1, 1'b0, F3_W, 9'h012, 32'h0);
        chk_eq("lw_mis_err", {31'h0, d_rsp_err}, 32'h1);
        chk_eq("lw_mis_dat", d_rsp_data, 32'h0);
        step(1'b0, '0, 1'b1, 1'b1, F3_H, 9'h011, 32'h00005555);
        chk_eq("sh_mis_err", {31'h0, d_rsp_err}, 32'h1);
        step(1'b0, '0, 1'b1, 1'b0, F3_W, 9'h010, 32'h0);
        chk_eq("sh_mis_unchanged", d_rsp_data, 32'h80ADBEEF);
        step(1'b0, '0, 1'b1, 1'b0, 3'b011, 9'h010, 32'h0);
        chk_eq("ld_f3_011_err", {31'h0, d_rsp_err}, 32'h1);
        step(1'b1, 9'h002, 1'b0, 1'b0, F3_W, '0, 32'h0);
        chk_eq("fetch_mis_err", {31'h0, if_rsp_err}, 32'h1);
        step(1'b1, 9'h1FC, 1'b0, 1'b0, F3_W, '0, 32'h0);
        chk_eq("fetch_last_word", if_rsp_data, mword(9'h1FC));
        idle();

        // Twelve cycles of contention: D,D,D,D,F,D,D,D,D,F,D,D.
        pat = 12'b110111101111;
        fa = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, ADDR_W'(fa), 1'b1, 1'b0, F3_W, 9'h010, 32'h0);
            chk_eq("grant_pattern", {31'h0, dut_dgnt}, {31'h0, pat[c]});
            if (last_gif) fa += 4;
        end
        idle();

        // Reset in the cycle after a load accept drops its response.
        step(1'b0, '0, 1'b1, 1'b0, F3_W, 9'h010, 32'h0);
        reset = 1'b1;
        #1;
        chk_eq("rst_drop_rsp", {31'h0, d_rsp_valid}, 32'h0);
        exp_d_vld = 1'b0; exp_if_vld = 1'b0; fetch_losses = 0;
        @(posedge clk);
        #1;
        chk_eq("rst_drop_rsp2", {31'h0, d_rsp_valid}, 32'h0);
        reset = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0, F3_W, 9'h010, 32'h0);
        chk_eq("mem_retained", d_rsp_data, 32'h80ADBEEF);

        // Random traffic; a request that lost arbitration is held unchanged.
        c_ifv = 1'b0; c_dv = 1'b0; c_ifa = '0; c_da = '0; c_we = 1'b0; c_f3 = F3_W; c_wd = '0;
        last_gif = 1'b1; last_gd = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (!(c_ifv && !last_gif)) begin
                c_ifv = ($urandom_range(0, 3) != 0);
                c_ifa = ADDR_W'($urandom);
                if ($urandom_range(0, 7) != 0) c_ifa[1:0] = 2'b00;
            end
            if (!(c_dv && !last_gd)) begin
                c_dv = ($urandom_range(0, 3) != 0);
                c_we = $urandom_range(0, 1) == 1;
                c_f3 = 3'($urandom_range(0, 7));
                c_da = ADDR_W'($urandom);
                c_wd = $urandom;
            end
            step(c_ifv, c_ifa, c_dv, c_we, c_f3, c_da, c_wd);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
